ex_issue: RTL and testbench

Issue scheduler for the single execution unit. It holds dispatched ALU/branch/jump micro-ops until both source operands are valid, snoops the EX and LSB result broadcasts to wake them up, and each cycle issues the oldest ready entry, ordered by ROB distance from the head, into the `ex` input registers. It sits between the decoder/dispatch stage and `ex`, and is the only driver of the `iRS_*` inputs of `ex`.

---
 rtl/ex_issue_pkg.sv | 16 +
 rtl/ex_issue_sel.sv | 46 ++++
 rtl/ex_issue.sv | 179 +++++++++++++++++
 tb/tb_ex_issue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_pkg.sv
// Shared widths and micro-op encodings for the EX issue scheduler.
package ex_issue_pkg;
  localparam int INS_OP_W  = 5;
  localparam int REG_DAT_W = 32;
  localparam int ROB_ADD_W = 4;
  localparam int EXQ_SIZE  = 8;
  localparam int EXQ_ADD_W = $clog2(EXQ_SIZE);

  typedef enum logic [INS_OP_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_ADDI = 5'd2,
    OP_BEQ  = 5'd3,
    OP_JAL  = 5'd4
  } op_e;
endpackage

// File: rtl/ex_issue_sel.sv
// Oldest-ready selector: binary compare tree over ROB distance from head.
module issue_sel
  import ex_issue_pkg::*;
#(
  parameter int ENTRIES = EXQ_SIZE,
  parameter int TAG_W   = ROB_ADD_W
) (
  input  logic [ENTRIES-1:0]            cand,
  input  logic [ENTRIES-1:0][TAG_W-1:0] tag,
  input  logic [TAG_W-1:0]              iRob_Head,
  output logic [ENTRIES-1:0]            gnt,
  output logic                          found
);
  // Heap layout: node k has children 2k+1 / 2k+2, leaves start at ENTRIES-1.
  localparam int NODES = 2*ENTRIES-1;
  localparam int IW    = $clog2(ENTRIES);

  logic [NODES-1:0]            nv;
  logic [NODES-1:0][TAG_W-1:0] na;
  logic [NODES-1:0][IW-1:0]    ni;

  // Leaves get age = tag - head (wraps), then each level keeps the younger-age child.
  always_comb begin
    nv = '0;
    na = '0;
    ni = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      nv[ENTRIES-1+i] = cand[i];
      na[ENTRIES-1+i] = tag[i] - iRob_Head;
      ni[ENTRIES-1+i] = IW'(i);
    end
    for (int k = ENTRIES-2; k >= 0; k--) begin
      if (nv[2*k+1] && (!nv[2*k+2] || na[2*k+1] < na[2*k+2])) begin
        na[k] = na[2*k+1];
        ni[k] = ni[2*k+1];
      end else begin
        na[k] = na[2*k+2];
        ni[k] = ni[2*k+2];
      end
      nv[k] = nv[2*k+1] | nv[2*k+2];
    end
  end

  assign found = nv[0];
  assign gnt   = found ? (ENTRIES'(1) << ni[0]) : '0;
endmodule

// File: rtl/ex_issue.sv
// Issue scheduler for the EX unit: holds micro-ops until operands arrive,
// snoops EX/LSB broadcasts, and issues the oldest ready entry each cycle.
module ex_issue
  import ex_issue_pkg::*;
#(
  parameter int ENTRIES = EXQ_SIZE,
  parameter int OP_W    = INS_OP_W,
  parameter int DAT_W   = REG_DAT_W,
  parameter int TAG_W   = ROB_ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iClr,
  input  logic [TAG_W-1:0] iRob_Head,
  input  logic             iDsp_En,
  input  logic [OP_W-1:0]  iDsp_Op,
  input  logic [DAT_W-1:0] iDsp_Pc,
  input  logic [DAT_W-1:0] iDsp_Imm,
  input  logic [TAG_W-1:0] iDsp_Qd,
  input  logic             iDsp_Rdy1,
  input  logic [DAT_W-1:0] iDsp_Vs1,
  input  logic [TAG_W-1:0] iDsp_Qs1,
  input  logic             iDsp_Rdy2,
  input  logic [DAT_W-1:0] iDsp_Vs2,
  input  logic [TAG_W-1:0] iDsp_Qs2,
  output logic             oDsp_Full,
  input  logic             iEx_En,
  input  logic [TAG_W-1:0] iEx_Qd,
  input  logic [DAT_W-1:0] iEx_Vd,
  input  logic             iLsb_En,
  input  logic [TAG_W-1:0] iLsb_Qd,
  input  logic [DAT_W-1:0] iLsb_Vd,
  output logic             oEx_En,
  output logic [OP_W-1:0]  oEx_Op,
  output logic [DAT_W-1:0] oEx_Pc,
  output logic [DAT_W-1:0] oEx_Imm,
  output logic [DAT_W-1:0] oEx_Vs1,
  output logic [DAT_W-1:0] oEx_Vs2,
  output logic [TAG_W-1:0] oEx_Qd
);
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DAT_W-1:0] pc;
    logic [DAT_W-1:0] imm;
    logic [TAG_W-1:0] qd;
    logic             rdy1;
    logic [DAT_W-1:0] vs1;
    logic [TAG_W-1:0] qs1;
    logic             rdy2;
    logic [DAT_W-1:0] vs2;
    logic [TAG_W-1:0] qs2;
  } ent_t;

  logic [ENTRIES-1:0]            vld;
  ent_t [ENTRIES-1:0]            ent, ent_n;
  ent_t                          dsp_ent;
  logic [ENTRIES-1:0]            cand, gnt, free_oh;
  logic [ENTRIES-1:0][TAG_W-1:0] qd_v;
  logic                          found, accept;
  logic [OP_W-1:0]               iss_op;
  logic [DAT_W-1:0]              iss_pc, iss_imm, iss_vs1, iss_vs2;
  logic [TAG_W-1:0]              iss_qd;

  // Snoop one source: EX broadcast first, then LSB. Returns {ready, value}.
  function automatic logic [DAT_W:0] wake(input logic rdy, input logic [DAT_W-1:0] v,
                                          input logic [TAG_W-1:0] q);
    if (rdy)                      return {1'b1, v};
    if (iEx_En && q == iEx_Qd)    return {1'b1, iEx_Vd};
    if (iLsb_En && q == iLsb_Qd)  return {1'b1, iLsb_Vd};
    return {1'b0, v};
  endfunction

  assign oDsp_Full = &vld;
  assign accept    = iDsp_En & ~oDsp_Full;

  // Candidate vector and per-slot tags for the selector.
  always_comb begin
    cand = '0;
    qd_v = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cand[i] = vld[i] & ent[i].rdy1 & ent[i].rdy2;
      qd_v[i] = ent[i].qd;
    end
  end

  issue_sel #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_sel (
    .cand      (cand),
    .tag       (qd_v),
    .iRob_Head (iRob_Head),
    .gnt       (gnt),
    .found     (found)
  );

  // Lowest-index free slot, one-hot.
  always_comb begin
    free_oh = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!vld[i]) free_oh = ENTRIES'(1) << i;
  end

  // Incoming entry with same-cycle broadcast bypass on its sources.
  always_comb begin
    dsp_ent     = '0;
    dsp_ent.op  = iDsp_Op;
    dsp_ent.pc  = iDsp_Pc;
    dsp_ent.imm = iDsp_Imm;
    dsp_ent.qd  = iDsp_Qd;
    dsp_ent.qs1 = iDsp_Qs1;
    dsp_ent.qs2 = iDsp_Qs2;
    {dsp_ent.rdy1, dsp_ent.vs1} = wake(iDsp_Rdy1, iDsp_Vs1, iDsp_Qs1);
    {dsp_ent.rdy2, dsp_ent.vs2} = wake(iDsp_Rdy2, iDsp_Vs2, iDsp_Qs2);
  end

  // Next slot contents: wakeup for residents, dispatch write into the free slot.
  always_comb begin
    ent_n = ent;
    for (int i = 0; i < ENTRIES; i++) begin
      {ent_n[i].rdy1, ent_n[i].vs1} = wake(ent[i].rdy1, ent[i].vs1, ent[i].qs1);
      {ent_n[i].rdy2, ent_n[i].vs2} = wake(ent[i].rdy2, ent[i].vs2, ent[i].qs2);
      if (accept && free_oh[i]) ent_n[i] = dsp_ent;
    end
  end

  // Issue mux; all-zero when nothing is granted.
  always_comb begin
    iss_op  = '0;
    iss_pc  = '0;
    iss_imm = '0;
    iss_vs1 = '0;
    iss_vs2 = '0;
    iss_qd  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (gnt[i]) begin
        iss_op  = ent[i].op;
        iss_pc  = ent[i].pc;
        iss_imm = ent[i].imm;
        iss_vs1 = ent[i].vs1;
        iss_vs2 = ent[i].vs2;
        iss_qd  = ent[i].qd;
      end
    end
  end

  // Slot state and issue registers; reset beats flush beats normal update, en freezes all.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld     <= '0;
      oEx_En  <= 1'b0;
      oEx_Op  <= '0;
      oEx_Pc  <= '0;
      oEx_Imm <= '0;
      oEx_Vs1 <= '0;
      oEx_Vs2 <= '0;
      oEx_Qd  <= '0;
    end else if (en) begin
      ent <= ent_n;
      if (iClr) begin
        vld     <= '0;
        oEx_En  <= 1'b0;
        oEx_Op  <= '0;
        oEx_Pc  <= '0;
        oEx_Imm <= '0;
        oEx_Vs1 <= '0;
        oEx_Vs2 <= '0;
        oEx_Qd  <= '0;
      end else begin
        vld     <= (vld & ~gnt) | (accept ? free_oh : '0);
        oEx_En  <= found;
        oEx_Op  <= iss_op;
        oEx_Pc  <= iss_pc;
        oEx_Imm <= iss_imm;
        oEx_Vs1 <= iss_vs1;
        oEx_Vs2 <= iss_vs2;
        oEx_Qd  <= iss_qd;
      end
    end
  end
endmodule

// File: tb/tb_ex_issue.sv
// Directed bench for ex_issue: per-cycle vector table plus multi-cycle sequences.
module tb_ex_issue;
  import ex_issue_pkg::*;
  localparam int N = 8, OW = 5, DW = 32, TW = 4;

  logic          clk = 1'b0;
  logic          rst, en, iClr;
  logic [TW-1:0] iRob_Head;
  logic          iDsp_En;
  logic [OW-1:0] iDsp_Op;
  logic [DW-1:0] iDsp_Pc, iDsp_Imm, iDsp_Vs1, iDsp_Vs2;
  logic [TW-1:0] iDsp_Qd, iDsp_Qs1, iDsp_Qs2;
  logic          iDsp_Rdy1, iDsp_Rdy2, oDsp_Full;
  logic          iEx_En, iLsb_En;
  logic [TW-1:0] iEx_Qd, iLsb_Qd;
  logic [DW-1:0] iEx_Vd, iLsb_Vd;
  logic          oEx_En;
  logic [OW-1:0] oEx_Op;
  logic [DW-1:0] oEx_Pc, oEx_Imm, oEx_Vs1, oEx_Vs2;
  logic [TW-1:0] oEx_Qd;

  ex_issue #(.ENTRIES(N), .OP_W(OW), .DAT_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .iClr(iClr), .iRob_Head(iRob_Head),
    .iDsp_En(iDsp_En), .iDsp_Op(iDsp_Op), .iDsp_Pc(iDsp_Pc), .iDsp_Imm(iDsp_Imm),
    .iDsp_Qd(iDsp_Qd), .iDsp_Rdy1(iDsp_Rdy1), .iDsp_Vs1(iDsp_Vs1), .iDsp_Qs1(iDsp_Qs1),
    .iDsp_Rdy2(iDsp_Rdy2), .iDsp_Vs2(iDsp_Vs2), .iDsp_Qs2(iDsp_Qs2), .oDsp_Full(oDsp_Full),
    .iEx_En(iEx_En), .iEx_Qd(iEx_Qd), .iEx_Vd(iEx_Vd),
    .iLsb_En(iLsb_En), .iLsb_Qd(iLsb_Qd), .iLsb_Vd(iLsb_Vd),
    .oEx_En(oEx_En), .oEx_Op(oEx_Op), .oEx_Pc(oEx_Pc), .oEx_Imm(oEx_Imm),
    .oEx_Vs1(oEx_Vs1), .oEx_Vs2(oEx_Vs2), .oEx_Qd(oEx_Qd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dsp, qd, r1, vs1, qs1, r2, vs2, qs2, imm;
    int bsel, btag, bval, head, clr;
    int e_en, e_qd, e_vs1, e_vs2, e_imm, e_full;
  } vec_t;

  vec_t tab[$];
  int checks = 0, passes = 0;

  function automatic vec_t mk(int dsp, int qd, int r1, int vs1, int qs1, int r2, int vs2,
                              int qs2, int imm, int bsel, int btag, int bval, int head,
                              int clr, int e_en, int e_qd, int e_vs1, int e_vs2,
                              int e_imm, int e_full);
    vec_t v;
    v.dsp = dsp; v.qd = qd; v.r1 = r1; v.vs1 = vs1; v.qs1 = qs1; v.r2 = r2; v.vs2 = vs2;
    v.qs2 = qs2; v.imm = imm; v.bsel = bsel; v.btag = btag; v.bval = bval; v.head = head;
    v.clr = clr; v.e_en = e_en; v.e_qd = e_qd; v.e_vs1 = e_vs1; v.e_vs2 = e_vs2;
    v.e_imm = e_imm; v.e_full = e_full;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected op/pc follow the dispatch encoding: ADDI iff imm!=0, pc = 0x100 + qd.
  task automatic chk_out(input string nm, input int e_en, input int e_qd, input int e_vs1,
                         input int e_vs2, input int e_imm, input int e_full);
    int e_op, e_pc;
    e_op = (e_en == 0) ? 0 : ((e_imm != 0) ? int'(OP_ADDI) : int'(OP_ADD));
    e_pc = (e_en == 0) ? 0 : 32'h100 + e_qd;
    chk({nm, " en"},   int'(oEx_En),    e_en);
    chk({nm, " qd"},   int'(oEx_Qd),    e_qd);
    chk({nm, " vs1"},  int'(oEx_Vs1),   e_vs1);
    chk({nm, " vs2"},  int'(oEx_Vs2),   e_vs2);
    chk({nm, " imm"},  int'(oEx_Imm),   e_imm);
    chk({nm, " op"},   int'(oEx_Op),    e_op);
    chk({nm, " pc"},   int'(oEx_Pc),    e_pc);
    chk({nm, " full"}, int'(oDsp_Full), e_full);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iDsp_En = 0; iDsp_Op = '0; iDsp_Pc = '0; iDsp_Imm = '0; iDsp_Qd = '0;
    iDsp_Rdy1 = 0; iDsp_Vs1 = '0; iDsp_Qs1 = '0; iDsp_Rdy2 = 0; iDsp_Vs2 = '0; iDsp_Qs2 = '0;
    iEx_En = 0; iEx_Qd = '0; iEx_Vd = '0; iLsb_En = 0; iLsb_Qd = '0; iLsb_Vd = '0;
    iClr = 0;
  endtask

  task automatic dsp(input int qd, input int r1, input int vs1, input int qs1,
                     input int r2, input int vs2, input int qs2, input int imm);
    iDsp_En = 1;
    iDsp_Op = (imm != 0) ? OP_ADDI : OP_ADD;
    iDsp_Pc = 32'h100 + qd;
    iDsp_Imm = imm; iDsp_Qd = TW'(qd);
    iDsp_Rdy1 = r1[0]; iDsp_Vs1 = vs1; iDsp_Qs1 = TW'(qs1);
    iDsp_Rdy2 = r2[0]; iDsp_Vs2 = vs2; iDsp_Qs2 = TW'(qs2);
  endtask

  task automatic bus(input int bsel, input int tag, input int val);
    if (bsel == 1) begin iEx_En = 1; iEx_Qd = TW'(tag); iEx_Vd = val; end
    if (bsel == 2) begin iLsb_En = 1; iLsb_Qd = TW'(tag); iLsb_Vd = val; end
  endtask

  initial begin
    // Single issue, wakeup, wrap-around age order, bypass, flush priority, back-to-back.
    tab.push_back(mk(1,3, 1,5,0, 1,0,0, 7,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 1,3,5,0,7,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,4, 0,0,2, 1,1,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    2,2,'h10,  0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 1,4,'h10,1,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,1, 0,0,7, 1,1,0, 0,    0,0,0,    14,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,15,0,0,7, 1,1,0, 0,    0,0,0,    14,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,0, 0,0,7, 1,1,0, 0,    0,0,0,    14,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    1,7,'h77, 14,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,    14,0, 1,15,'h77,1,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,    14,0, 1,0,'h77,1,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,    14,0, 1,1,'h77,1,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,    14,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,5, 0,0,6, 1,2,0, 0,    1,6,'hAB,  0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 1,5,'hAB,2,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,2, 1,3,0, 0,0,9, 0,    2,9,'h55,  0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 1,2,3,'h55,0,0));
    tab.push_back(mk(1,6, 1,1,0, 1,1,0, 0,    0,0,0,     0,1, 0,0,0,0,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,7, 1,8,0, 1,9,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,8, 1,10,0,1,11,0,0,    0,0,0,     0,0, 1,7,8,9,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 1,8,10,11,0,0));
    tab.push_back(mk(0,0, 0,0,0, 0,0,0, 0,    0,0,0,     0,0, 0,0,0,0,0,0));

    rst = 0; en = 1; iRob_Head = '0;
    idle_in();
    tick(); tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1;

    foreach (tab[i]) begin
      idle_in();
      iRob_Head = TW'(tab[i].head);
      if (tab[i].dsp != 0)
        dsp(tab[i].qd, tab[i].r1, tab[i].vs1, tab[i].qs1, tab[i].r2, tab[i].vs2,
            tab[i].qs2, tab[i].imm);
      bus(tab[i].bsel, tab[i].btag, tab[i].bval);
      iClr = tab[i].clr[0];
      tick();
      chk_out($sformatf("v%0d", i), tab[i].e_en, tab[i].e_qd, tab[i].e_vs1,
              tab[i].e_vs2, tab[i].e_imm, tab[i].e_full);
    end
    idle_in();
    iRob_Head = '0;

    // Fill all slots waiting on tag 9, in reverse age order so slot index != age.
    for (int k = 0; k < N; k++) begin
      dsp(7-k, 0, 0, 9, 1, 'h20 + 7 - k, 0, 0);
      tick();
      chk("fill en", int'(oEx_En), 0);
    end
    chk("full set", int'(oDsp_Full), 1);
    dsp(8, 1, 1, 0, 1, 1, 0, 0);
    tick();
    chk_out("drop9", 0, 0, 0, 0, 0, 1);
    idle_in();
    bus(1, 9, 'h99);
    tick();
    chk_out("wake9", 0, 0, 0, 0, 0, 1);
    idle_in();
    for (int j = 0; j < N; j++) begin
      tick();
      chk_out($sformatf("drain%0d", j), 1, j, 'h99, 'h20 + j, 0, 0);
    end
    tick();
    chk_out("drained", 0, 0, 0, 0, 0, 0);

    // Flush with residents and an issue in flight.
    for (int k = 0; k < 5; k++) begin
      dsp(k, 0, 0, 9, 1, 1, 0, 0);
      tick();
    end
    idle_in();
    chk("five full", int'(oDsp_Full), 0);
    bus(1, 9, 'h42);
    tick();
    idle_in();
    tick();
    chk_out("pre-clr", 1, 0, 'h42, 1, 0, 0);
    iClr = 1;
    tick();
    iClr = 0;
    chk_out("clr", 0, 0, 0, 0, 0, 0);
    bus(1, 9, 'h42);
    for (int j = 0; j < 4; j++) begin
      tick();
      idle_in();
      chk_out($sformatf("post-clr%0d", j), 0, 0, 0, 0, 0, 0);
    end

    // Enable freeze, broadcasts ignored while frozen, then reset under en=0.
    dsp(4, 0, 0, 9, 1, 2, 0, 0);
    tick();
    dsp(3, 1, 'h31, 0, 1, 'h32, 0, 0);
    tick();
    idle_in();
    tick();
    chk_out("A issue", 1, 3, 'h31, 'h32, 0, 0);
    en = 0;
    bus(1, 9, 'h66);
    tick();
    chk_out("hold1", 1, 3, 'h31, 'h32, 0, 0);
    tick();
    chk_out("hold2", 1, 3, 'h31, 'h32, 0, 0);
    idle_in();
    en = 1;
    tick();
    chk_out("unfrz", 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("no-wake", 0, 0, 0, 0, 0, 0);
    dsp(6, 0, 0, 9, 1, 3, 0, 0);
    tick();
    dsp(5, 1, 'h51, 0, 1, 'h52, 0, 0);
    tick();
    idle_in();
    tick();
    chk_out("C issue", 1, 5, 'h51, 'h52, 0, 0);
    en = 0;
    rst = 0;
    tick();
    chk_out("rst-en0", 0, 0, 0, 0, 0, 0);
    rst = 1;
    en = 1;
    bus(1, 9, 'h77);
    tick();
    idle_in();
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_out($sformatf("post-rst%0d", j), 0, 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
